// File: rtl/motor_ctrl_pkg.sv
// Shared widths, state encoding and command clamp for the motor drive sequencer.
package motor_ctrl_pkg;

  localparam int unsigned CMD_W   = 10;
  localparam int unsigned MAX_CMD = 280;

  typedef logic [CMD_W-1:0] cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    BRAKE = 3'd3,
    FAULT = 3'd4
  } motor_state_t;

  // Limit a raw throttle request to the highest duty the generator accepts.
  function automatic cmd_t clamp_cmd(input cmd_t raw);
    return (raw > cmd_t'(MAX_CMD)) ? cmd_t'(MAX_CMD) : raw;
  endfunction

endpackage

// File: rtl/motor_ramp_tick.sv
// Ramp-rate divider: one-cycle tick every RAMP_DIV clocks, synchronously restartable.
module motor_ramp_tick #(
  parameter int unsigned RAMP_DIV = 50000
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/motor_drive_sequencer.sv
// Duty-command sequencer for the PWM generator: soft-start ramp, brake, enable gating.
// Optional throttle-staleness watchdog enabled by defining MOTOR_SEQ_WDOG_EN.
module motor_drive_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 50000,
  parameter int unsigned STEP     = 4,
  parameter int unsigned WDOG_CYC = 5000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             brake,
  input  logic [CMD_W-1:0] throttle,
  input  logic             throttle_valid,
  output logic [CMD_W-1:0] pwm_cmd,
  output logic [2:0]       state,
  output logic             fault
);

  localparam int unsigned SUM_W = CMD_W + 1;

  motor_state_t     state_q;
  motor_state_t     state_d;
  logic [CMD_W-1:0] target_q;
  logic [CMD_W-1:0] pwm_d;
  logic             tick;
  logic             ramp_clear;
  logic             wdog_expire;
  logic             moving;
  logic [SUM_W-1:0] headroom;
  logic [SUM_W-1:0] step_amt;
  logic [SUM_W-1:0] ramp_sum;
  logic [CMD_W-1:0] ramp_val;

  assign moving     = (state_q == RAMP) || (state_q == RUN);
  // Tick phase restarts whenever the ramp is (re)entered so the first step is a full period away.
  assign ramp_clear = reset || ((state_d == RAMP) && (state_q != RAMP));

  motor_ramp_tick #(
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp_tick (
    .clk   (CLOCK_50),
    .clear (ramp_clear),
    .tick  (tick)
  );

  // One ramp step toward target, computed one bit wider and bounded by target.
  always_comb begin
    headroom = SUM_W'(target_q) - SUM_W'(pwm_cmd);
    step_amt = (headroom > SUM_W'(STEP)) ? SUM_W'(STEP) : headroom;
    ramp_sum = SUM_W'(pwm_cmd) + step_amt;
    ramp_val = (ramp_sum > SUM_W'(target_q)) ? target_q : ramp_sum[CMD_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_cmd;
    if (state_q == FAULT) begin
      pwm_d = '0;
      if (!brake && throttle_valid && (throttle == '0)) begin
        state_d = IDLE;
      end
    end else if (brake) begin
      state_d = BRAKE;
      pwm_d   = '0;
    end else if (wdog_expire) begin
      state_d = FAULT;
      pwm_d   = '0;
    end else if (!enable && moving) begin
      state_d = IDLE;
      pwm_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pwm_d = '0;
          if (enable && (target_q != '0)) begin
            state_d = RAMP;
          end
        end
        RAMP: begin
          if (target_q == '0) begin
            state_d = IDLE;
            pwm_d   = '0;
          end else if (target_q < pwm_cmd) begin
            // Deceleration is applied at once, never ramped.
            state_d = RUN;
            pwm_d   = target_q;
          end else if (tick) begin
            pwm_d = ramp_val;
            if (ramp_val == target_q) begin
              state_d = RUN;
            end
          end else if (pwm_cmd == target_q) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (target_q == '0) begin
            state_d = IDLE;
            pwm_d   = '0;
          end else if (target_q > pwm_cmd) begin
            state_d = RAMP;
          end else if (target_q < pwm_cmd) begin
            pwm_d = target_q;
          end
        end
        BRAKE: begin
          // Re-arm: throttle must be back at zero before the motor may restart.
          pwm_d = '0;
          if (target_q == '0) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          pwm_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      pwm_cmd  <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      pwm_cmd <= pwm_d;
      if (throttle_valid) begin
        target_q <= clamp_cmd(throttle);
      end
    end
  end

  assign state = state_q;

`ifdef MOTOR_SEQ_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

  logic [WDOG_W-1:0] wdog_q;
  logic              fault_q;

  // Counts cycles since the last throttle strobe, only while the motor is driven.
  always_ff @(posedge CLOCK_50) begin
    if (reset || !moving || throttle_valid) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WDOG_W'(1);
    end
  end

  assign wdog_expire = moving && (wdog_q == WDOG_W'(WDOG_CYC - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_d == FAULT);
    end
  end

  assign fault = fault_q;
`else
  logic unused_wdog_cfg;

  assign unused_wdog_cfg = ^WDOG_CYC;
  assign wdog_expire     = 1'b0;
  assign fault           = 1'b0;
`endif

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Self-checking bench for motor_drive_sequencer against a rule-level reference model.
// Define MOTOR_SEQ_WDOG_EN to exercise the watchdog build.
module tb_motor_drive_sequencer;

  localparam int RAMP_DIV = 4;
  localparam int STEP     = 8;
  localparam int MAX_CMD  = 280;
  localparam int WDOG_CYC = 100;
`ifdef MOTOR_SEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RAMP = 1, S_RUN = 2, S_BRAKE = 3, S_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       brake = 1'b0;
  logic [9:0] throttle = '0;
  logic       throttle_valid = 1'b0;
  logic [9:0] pwm_cmd;
  logic [2:0] state;
  logic       fault;

  int errors = 0;
  int checks = 0;

  motor_drive_sequencer #(
    .RAMP_DIV (RAMP_DIV),
    .STEP     (STEP),
    .WDOG_CYC (WDOG_CYC)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .enable         (enable),
    .brake          (brake),
    .throttle       (throttle),
    .throttle_valid (throttle_valid),
    .pwm_cmd        (pwm_cmd),
    .state          (state),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Reference model: mode, duty, latched target, cycles spent ramping, cycles without a strobe.
  int m_state = 0, m_pwm = 0, m_target = 0, m_age = 0, m_wd = 0;

  always @(posedge clk) begin : model
    int ns;
    int np;
    bit tk;
    bit wd_hit;
    if (reset) begin
      m_state = S_IDLE; m_pwm = 0; m_target = 0; m_age = 0; m_wd = 0;
    end else begin
      tk     = (m_state == S_RAMP) && (m_age > 0) && ((m_age % RAMP_DIV) == 0);
      wd_hit = WDOG_ON && (m_state == S_RAMP || m_state == S_RUN) && (m_wd == WDOG_CYC - 1);
      ns = m_state;
      np = m_pwm;
      if (m_state == S_FAULT) begin
        np = 0;
        if (!brake && throttle_valid && throttle == 0) ns = S_IDLE;
      end else if (brake) begin
        ns = S_BRAKE; np = 0;
      end else if (wd_hit) begin
        ns = S_FAULT; np = 0;
      end else if (!enable && (m_state == S_RAMP || m_state == S_RUN)) begin
        ns = S_IDLE; np = 0;
      end else begin
        case (m_state)
          S_IDLE: begin
            np = 0;
            if (enable && m_target > 0) ns = S_RAMP;
          end
          S_RAMP, S_RUN: begin
            if (m_target == 0) begin
              ns = S_IDLE; np = 0;
            end else begin
              if (m_target < m_pwm) np = m_target;
              else if (tk) np = m_pwm + (((m_target - m_pwm) < STEP) ? (m_target - m_pwm) : STEP);
              ns = (np == m_target) ? S_RUN : S_RAMP;
            end
          end
          S_BRAKE: begin
            np = 0;
            if (m_target == 0) ns = S_IDLE;
          end
          default: begin
            ns = S_IDLE; np = 0;
          end
        endcase
      end
      m_age = (ns == S_RAMP && m_state == S_RAMP) ? m_age + 1 : 0;
      m_wd  = ((m_state == S_RAMP || m_state == S_RUN) && !throttle_valid) ? m_wd + 1 : 0;
      if (throttle_valid) m_target = (throttle > MAX_CMD) ? MAX_CMD : int'(throttle);
      m_state = ns;
      m_pwm   = np;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    throttle       = 10'(v);
    throttle_valid = 1'b1;
    cyc();
    throttle_valid = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b1; brake = 1'b0; enable = 1'b0; throttle_valid = 1'b0;
    cyc();
    reset  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if (pwm_cmd !== 10'd0) begin errors++; $display("FAIL reset_pwm: got %0d want 0", pwm_cmd); end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0d want 0", fault); end
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    int seen[$];
    int at[$];
    int last;
    restart();
    strobe(40);
    last = 0;
    for (int c = 1; c <= 80 && state !== 3'd2; c++) begin
      cyc();
      checks++;
      if ({pwm_cmd, state, fault} !== {10'(m_pwm), 3'(m_state), 1'(m_state == S_FAULT)}) begin
        errors++;
        $display("FAIL ramp_track: got pwm=%0d st=%0d flt=%0d want pwm=%0d st=%0d", pwm_cmd, state, fault, m_pwm, m_state);
      end
      if (int'(pwm_cmd) != last) begin
        seen.push_back(int'(pwm_cmd)); at.push_back(c); last = int'(pwm_cmd);
      end
    end
    checks++;
    if (seen.size() != 5) begin errors++; $display("FAIL ramp_steps: got %0d steps want 5", seen.size()); end
    for (int i = 0; i < seen.size() && i < 5; i++) begin
      checks++;
      if (seen[i] != 8 * (i + 1) || at[i] != 6 + 4 * i) begin
        errors++;
        $display("FAIL ramp_step%0d: got pwm=%0d at cycle %0d want pwm=%0d at cycle %0d", i, seen[i], at[i], 8 * (i + 1), 6 + 4 * i);
      end
    end
    checks++;
    if (state !== 3'd2 || pwm_cmd !== 10'd40) begin errors++; $display("FAIL ramp_run: got st=%0d pwm=%0d want st=2 pwm=40", state, pwm_cmd); end
  endtask

  task automatic test_decel();
    strobe(10);
    checks++;
    if (pwm_cmd !== 10'd40 || state !== 3'd2) begin errors++; $display("FAIL decel_latch: got pwm=%0d st=%0d want pwm=40 st=2", pwm_cmd, state); end
    cyc();
    checks++;
    if (pwm_cmd !== 10'd10 || state !== 3'd2) begin errors++; $display("FAIL decel_apply: got pwm=%0d st=%0d want pwm=10 st=2", pwm_cmd, state); end
  endtask

  task automatic test_clamp();
    int peak;
    strobe(1000);
    peak = 0;
    for (int c = 1; c <= 400 && !(state === 3'd2 && pwm_cmd === 10'd280); c++) begin
      throttle_valid = (c % 32 == 0);
      cyc();
      throttle_valid = 1'b0;
      if (int'(pwm_cmd) > peak) peak = int'(pwm_cmd);
      checks++;
      if ({pwm_cmd, state, fault} !== {10'(m_pwm), 3'(m_state), 1'(m_state == S_FAULT)}) begin
        errors++;
        $display("FAIL clamp_track: got pwm=%0d st=%0d flt=%0d want pwm=%0d st=%0d", pwm_cmd, state, fault, m_pwm, m_state);
      end
    end
    repeat (8) cyc();
    if (int'(pwm_cmd) > peak) peak = int'(pwm_cmd);
    checks++;
    if (peak != 280) begin errors++; $display("FAIL clamp_peak: got %0d want 280", peak); end
    checks++;
    if (state !== 3'd2 || pwm_cmd !== 10'd280) begin errors++; $display("FAIL clamp_end: got st=%0d pwm=%0d want st=2 pwm=280", state, pwm_cmd); end
  endtask

  task automatic test_brake();
    restart();
    strobe(40);
    for (int c = 0; c < 60 && pwm_cmd !== 10'd24; c++) cyc();
    checks++;
    if (pwm_cmd !== 10'd24) begin errors++; $display("FAIL brake_reach24: got %0d want 24", pwm_cmd); end
    brake = 1'b1;
    cyc();
    checks++;
    if (pwm_cmd !== 10'd0 || state !== 3'd3) begin errors++; $display("FAIL brake_apply: got pwm=%0d st=%0d want pwm=0 st=3", pwm_cmd, state); end
    brake = 1'b0;
    repeat (5) cyc();
    checks++;
    if (pwm_cmd !== 10'd0 || state !== 3'd3) begin errors++; $display("FAIL brake_hold: got pwm=%0d st=%0d want pwm=0 st=3", pwm_cmd, state); end
    strobe(0);
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL brake_latch: got st=%0d want 3", state); end
    cyc();
    checks++;
    if (state !== 3'd0 || pwm_cmd !== 10'd0) begin errors++; $display("FAIL brake_exit: got st=%0d pwm=%0d want st=0 pwm=0", state, pwm_cmd); end
  endtask

  task automatic test_watchdog();
    int n;
    restart();
    strobe(20);
`ifdef MOTOR_SEQ_WDOG_EN
    n = 0;
    for (int c = 1; c <= 200 && state !== 3'd4; c++) begin
      cyc();
      n = c;
      checks++;
      if ({pwm_cmd, state, fault} !== {10'(m_pwm), 3'(m_state), 1'(m_state == S_FAULT)}) begin
        errors++;
        $display("FAIL wdog_track: got pwm=%0d st=%0d flt=%0d want pwm=%0d st=%0d", pwm_cmd, state, fault, m_pwm, m_state);
      end
    end
    checks++;
    if (n != WDOG_CYC + 1) begin errors++; $display("FAIL wdog_latency: got %0d cycles want %0d", n, WDOG_CYC + 1); end
    checks++;
    if (state !== 3'd4 || fault !== 1'b1 || pwm_cmd !== 10'd0) begin errors++; $display("FAIL wdog_fault: got st=%0d flt=%0d pwm=%0d want st=4 flt=1 pwm=0", state, fault, pwm_cmd); end
    strobe(20);
    cyc();
    checks++;
    if (state !== 3'd4 || fault !== 1'b1) begin errors++; $display("FAIL wdog_nonzero: got st=%0d flt=%0d want st=4 flt=1", state, fault); end
    brake = 1'b1;
    cyc();
    checks++;
    if (state !== 3'd4) begin errors++; $display("FAIL wdog_brake: got st=%0d want 4", state); end
    brake = 1'b0;
    strobe(0);
    checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL wdog_exit: got st=%0d flt=%0d want st=0 flt=0", state, fault); end
`else
    n = 0;
    for (int c = 1; c <= 300; c++) begin
      cyc();
      if (state === 3'd4 || fault !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL nowdog_fault: got %0d faulty cycles want 0", n); end
    checks++;
    if (state !== 3'd2 || pwm_cmd !== 10'd20) begin errors++; $display("FAIL nowdog_run: got st=%0d pwm=%0d want st=2 pwm=20", state, pwm_cmd); end
`endif
  endtask

  task automatic test_reset_mid();
    restart();
    strobe(40);
    for (int c = 0; c < 60 && pwm_cmd !== 10'd16; c++) cyc();
    checks++;
    if (pwm_cmd !== 10'd16 || state !== 3'd1) begin errors++; $display("FAIL rmid_reach16: got pwm=%0d st=%0d want pwm=16 st=1", pwm_cmd, state); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if ({pwm_cmd, state, fault} !== 14'd0) begin errors++; $display("FAIL rmid_reset: got pwm=%0d st=%0d flt=%0d want all 0", pwm_cmd, state, fault); end
    repeat (6) cyc();
    checks++;
    if (state !== 3'd0 || pwm_cmd !== 10'd0) begin errors++; $display("FAIL rmid_target: got st=%0d pwm=%0d want st=0 pwm=0", state, pwm_cmd); end
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 3000 && errors < 20; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0) brake = ~brake;
      reset          = ($urandom_range(0, 499) == 0);
      throttle_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       throttle = 10'd0;
        1:       throttle = 10'($urandom_range(1, 60));
        2:       throttle = 10'($urandom_range(200, 1023));
        default: throttle = 10'($urandom_range(0, 300));
      endcase
      cyc();
      checks++;
      if ({pwm_cmd, state, fault} !== {10'(m_pwm), 3'(m_state), 1'(m_state == S_FAULT)}) begin
        errors++;
        $display("FAIL random_track@%0d: got pwm=%0d st=%0d flt=%0d want pwm=%0d st=%0d", i, pwm_cmd, state, fault, m_pwm, m_state);
      end
    end
    reset = 1'b0; throttle_valid = 1'b0; brake = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_decel();
    test_clamp();
    test_brake();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within 1 ms");
    $fatal(1);
  end

endmodule
